// File: rtl/color_tracker_pkg.sv
// rtl/color_tracker_pkg.sv - shared widths, colour coefficients, FSM encodings and helpers
package color_tracker_pkg;

    localparam int COORD_W = 13;
    localparam int CNT_W   = 21;
    localparam int SUM_W   = 34;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    // RGB -> YUV fixed-point coefficients (all scaled by 256)
    localparam logic [7:0] K_YR = 8'd77;
    localparam logic [7:0] K_YG = 8'd150;
    localparam logic [7:0] K_YB = 8'd37;
    localparam logic [7:0] K_U  = 8'd126;
    localparam logic [7:0] K_V  = 8'd225;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Magnitude of a 10-bit signed difference; -512 never occurs for our operand ranges
    function automatic logic [9:0] abs10(input logic signed [9:0] d);
        return d[9] ? 10'(-d) : 10'(d);
    endfunction

endpackage

// File: rtl/color_tracker_serial_divider.sv
// rtl/color_tracker_serial_divider.sv - restoring divider, one quotient bit per cycle, saturating result
module serial_divider
    import color_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [SUM_W-1:0]   dividend,
    input  logic [CNT_W-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] quotient
);

    logic [CNT_W-1:0] rem;
    logic [SUM_W-1:0] quo;
    logic [5:0]       bits_left;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_sub;
    logic             ge;
    logic             unused_div;

    // The remainder stays below the divisor, so the shifted value fits CNT_W+1 bits
    assign rem_sh     = {rem, quo[SUM_W-1]};
    assign ge         = rem_sh >= {1'b0, divisor};
    assign rem_sub    = rem_sh - {1'b0, divisor};
    assign quotient   = (|quo[SUM_W-1:COORD_W]) ? COORD_MAX : quo[COORD_W-1:0];
    assign unused_div = rem_sh[CNT_W] ^ rem_sub[CNT_W];

    // Shift/subtract iteration; dividend bits are shifted out as quotient bits shift in
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem       <= '0;
            quo       <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem       <= '0;
                quo       <= dividend;
                bits_left <= 6'(SUM_W);
                busy      <= 1'b1;
            end else if (busy) begin
                rem       <= ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                quo       <= {quo[SUM_W-2:0], ge};
                bits_left <= bits_left - 6'd1;
                if (bits_left == 6'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/color_tracker.sv
// rtl/color_tracker.sv - colour-match mask pipeline, per-frame bounding box and centroid
module color_tracker
    import color_tracker_pkg::*;
#(
    parameter logic [CNT_W-1:0] MIN_PIX = 21'd16,
    localparam int              LAT     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         raw_R,
    input  logic [7:0]         raw_G,
    input  logic [7:0]         raw_B,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               pix_valid,
    input  logic               sof,
    input  logic               eof,
    input  logic [7:0]         ref_Y,
    input  logic signed [8:0]  ref_U,
    input  logic signed [8:0]  ref_V,
    input  logic               cal_done,
    input  logic [7:0]         thr_Y,
    input  logic [7:0]         thr_U,
    input  logic [7:0]         thr_V,
    output logic               mask,
    output logic [COORD_W-1:0] mask_row,
    output logic [COORD_W-1:0] mask_col,
    output logic               mask_valid,
    output logic [COORD_W-1:0] box_rmin,
    output logic [COORD_W-1:0] box_rmax,
    output logic [COORD_W-1:0] box_cmin,
    output logic [COORD_W-1:0] box_cmax,
    output logic [COORD_W-1:0] cen_row,
    output logic [COORD_W-1:0] cen_col,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               result_valid,
    output logic               result_stb,
    output logic               overrun
);

    // Stage 1: colour conversion; Y is non-negative and may reach 262, so it is kept unsigned
    logic [16:0]        y_sum;
    logic [8:0]         y_c;
    logic signed [17:0] b_m_y, r_m_y, u_prod, v_prod;
    logic [8:0]         s1_y;
    logic signed [8:0]  s1_u, s1_v;
    logic [COORD_W-1:0] s1_row, s1_col;
    logic               s1_valid;

    assign y_sum  = 17'(K_YR) * 17'(raw_R) + 17'(K_YG) * 17'(raw_G) + 17'(K_YB) * 17'(raw_B);
    assign y_c    = y_sum[16:8];
    assign b_m_y  = $signed({10'd0, raw_B}) - $signed({9'd0, y_c});
    assign r_m_y  = $signed({10'd0, raw_R}) - $signed({9'd0, y_c});
    assign u_prod = b_m_y * $signed({10'd0, K_U});
    assign v_prod = r_m_y * $signed({10'd0, K_V});

    // Register converted colour with its coordinates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_y <= '0; s1_u <= '0; s1_v <= '0;
            s1_row <= '0; s1_col <= '0; s1_valid <= 1'b0;
        end else begin
            s1_y     <= y_c;
            s1_u     <= u_prod[16:8];
            s1_v     <= v_prod[16:8];
            s1_row   <= row;
            s1_col   <= col;
            s1_valid <= pix_valid;
        end
    end

    // Stage 2: tolerance window against the calibrated reference
    logic signed [9:0] dy, du, dv;
    logic              in_win;

    assign dy     = $signed({1'b0, s1_y}) - $signed({2'b00, ref_Y});
    assign du     = $signed({s1_u[8], s1_u}) - $signed({ref_U[8], ref_U});
    assign dv     = $signed({s1_v[8], s1_v}) - $signed({ref_V[8], ref_V});
    assign in_win = (abs10(dy) <= {2'b00, thr_Y}) && (abs10(du) <= {2'b00, thr_U})
                 && (abs10(dv) <= {2'b00, thr_V});

    // Register the mask; it is forced low whenever the pixel is not qualified
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= 1'b0; mask_valid <= 1'b0; mask_row <= '0; mask_col <= '0;
        end else begin
            mask       <= s1_valid && cal_done && in_win;
            mask_valid <= s1_valid;
            mask_row   <= s1_row;
            mask_col   <= s1_col;
        end
    end

    // eof is aligned with the mask output so the last in-flight pixel is counted
    logic [LAT-1:0] eof_sr;
    logic           eof_d;
    logic [1:0]     state;
    logic           eof_take;

    assign eof_d    = eof_sr[LAT-1];
    assign eof_take = eof_d && (state == ST_IDLE);

    // Delay line for eof
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) eof_sr <= '0;
        else          eof_sr <= {eof_sr[LAT-2:0], eof};
    end

    logic               hit;
    logic [CNT_W-1:0]   acc_cnt, cnt_n;
    logic [SUM_W-1:0]   acc_rsum, acc_csum, rsum_n, csum_n;
    logic [COORD_W-1:0] acc_rmin, acc_rmax, acc_cmin, acc_cmax;
    logic [COORD_W-1:0] rmin_n, rmax_n, cmin_n, cmax_n;

    assign hit = mask_valid && mask;

    // Next accumulator values: sof clears first so a coincident pixel becomes the first one
    always_comb begin
        cnt_n = acc_cnt;   rsum_n = acc_rsum; csum_n = acc_csum;
        rmin_n = acc_rmin; rmax_n = acc_rmax; cmin_n = acc_cmin; cmax_n = acc_cmax;
        if (sof) begin
            cnt_n = '0; rsum_n = '0; csum_n = '0;
            rmin_n = COORD_MAX; rmax_n = '0; cmin_n = COORD_MAX; cmax_n = '0;
        end
        if (hit) begin
            if (cnt_n != '1) cnt_n = cnt_n + CNT_W'(1);
            rsum_n = rsum_n + SUM_W'(mask_row);
            csum_n = csum_n + SUM_W'(mask_col);
            if (mask_row < rmin_n) rmin_n = mask_row;
            if (mask_row > rmax_n) rmax_n = mask_row;
            if (mask_col < cmin_n) cmin_n = mask_col;
            if (mask_col > cmax_n) cmax_n = mask_col;
        end
    end

    // Live accumulators restart from empty when a frame is handed to the divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || eof_take) begin
            acc_cnt <= '0; acc_rsum <= '0; acc_csum <= '0;
            acc_rmin <= COORD_MAX; acc_rmax <= '0; acc_cmin <= COORD_MAX; acc_cmax <= '0;
        end else begin
            acc_cnt <= cnt_n; acc_rsum <= rsum_n; acc_csum <= csum_n;
            acc_rmin <= rmin_n; acc_rmax <= rmax_n; acc_cmin <= cmin_n; acc_cmax <= cmax_n;
        end
    end

    logic [CNT_W-1:0]   snap_cnt;
    logic [SUM_W-1:0]   snap_rsum, snap_csum;
    logic [COORD_W-1:0] snap_rmin, snap_rmax, snap_cmin, snap_cmax;
    logic               phase, div_start, div_busy, div_done, finish;
    logic [COORD_W-1:0] div_q, row_q;
    logic               unused_top;

    assign finish     = (state == ST_DIVIDE) && ((snap_cnt == '0) || (div_done && phase));
    assign unused_top = ^{y_sum[7:0], u_prod[17], u_prod[7:0], v_prod[17], v_prod[7:0], div_busy};

    serial_divider u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (phase ? snap_csum : snap_rsum),
        .divisor  (snap_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    // Frame FSM: snapshot on eof, divide row then col sum, publish results for one strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE; phase <= 1'b0; div_start <= 1'b0; row_q <= '0;
            snap_cnt <= '0; snap_rsum <= '0; snap_csum <= '0;
            snap_rmin <= COORD_MAX; snap_rmax <= '0; snap_cmin <= COORD_MAX; snap_cmax <= '0;
            box_rmin <= '0; box_rmax <= '0; box_cmin <= '0; box_cmax <= '0;
            cen_row <= '0; cen_col <= '0; match_cnt <= '0;
            result_valid <= 1'b0; result_stb <= 1'b0; overrun <= 1'b0;
        end else begin
            div_start  <= 1'b0;
            result_stb <= 1'b0;
            if (eof_d && state != ST_IDLE) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (eof_d) begin
                        snap_cnt <= cnt_n; snap_rsum <= rsum_n; snap_csum <= csum_n;
                        snap_rmin <= rmin_n; snap_rmax <= rmax_n;
                        snap_cmin <= cmin_n; snap_cmax <= cmax_n;
                        phase     <= 1'b0;
                        div_start <= (cnt_n != '0);
                        state     <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done && !phase) begin
                        row_q     <= div_q;
                        phase     <= 1'b1;
                        div_start <= 1'b1;
                    end
                    if (finish) begin
                        box_rmin <= snap_rmin; box_rmax <= snap_rmax;
                        box_cmin <= snap_cmin; box_cmax <= snap_cmax;
                        cen_row  <= (snap_cnt == '0) ? '0 : row_q;
                        cen_col  <= (snap_cnt == '0) ? '0 : div_q;
                        match_cnt    <= snap_cnt;
                        result_valid <= (snap_cnt >= MIN_PIX);
                        result_stb   <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_tracker.sv
// tb/tb_color_tracker.sv - self-checking bench for color_tracker
module tb_color_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [7:0]        raw_R, raw_G, raw_B;
    logic [12:0]       row, col;
    logic              pix_valid, sof, eof;
    logic [7:0]        ref_Y;
    logic signed [8:0] ref_U, ref_V;
    logic              cal_done;
    logic [7:0]        thr_Y, thr_U, thr_V;
    logic              mask, mask_valid;
    logic [12:0]       mask_row, mask_col;
    logic [12:0]       box_rmin, box_rmax, box_cmin, box_cmax, cen_row, cen_col;
    logic [20:0]       match_cnt;
    logic              result_valid, result_stb, overrun;

    color_tracker dut (
        .clk(clk), .reset_n(reset_n), .raw_R(raw_R), .raw_G(raw_G), .raw_B(raw_B),
        .row(row), .col(col), .pix_valid(pix_valid), .sof(sof), .eof(eof),
        .ref_Y(ref_Y), .ref_U(ref_U), .ref_V(ref_V), .cal_done(cal_done),
        .thr_Y(thr_Y), .thr_U(thr_U), .thr_V(thr_V),
        .mask(mask), .mask_row(mask_row), .mask_col(mask_col), .mask_valid(mask_valid),
        .box_rmin(box_rmin), .box_rmax(box_rmax), .box_cmin(box_cmin), .box_cmax(box_cmax),
        .cen_row(cen_row), .cen_col(cen_col), .match_cnt(match_cnt),
        .result_valid(result_valid), .result_stb(result_stb), .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;
    int m_refy, m_refu, m_refv, m_thy, m_thu, m_thv;
    bit p_v, p_m, c_v, c_m;
    int p_row, p_col, c_row, c_col;
    longint f_cnt, f_rsum, f_csum, e_cnt, e_rsum, e_csum;
    int f_rmin, f_rmax, f_cmin, f_cmax, e_rmin, e_rmax, e_cmin, e_cmax;
    int stb_cnt;
    bit eof_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int clamp8(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    // Reference colour test straight from the conversion formulas
    function automatic bit model_match(input int r, input int g, input int b);
        int y, u, v;
        y = (77 * r + 150 * g + 37 * b) / 256;
        u = (126 * (b - y)) >>> 8;
        v = (225 * (r - y)) >>> 8;
        return cal_done && iabs(y - m_refy) <= m_thy && iabs(u - m_refu) <= m_thu
               && iabs(v - m_refv) <= m_thv;
    endfunction

    task automatic set_ref(input int y, input int u, input int v, input int ty, input int tu, input int tv);
        m_refy = y; m_refu = u; m_refv = v; m_thy = ty; m_thu = tu; m_thv = tv;
        ref_Y = 8'(y); ref_U = 9'(u); ref_V = 9'(v);
        thr_Y = 8'(ty); thr_U = 8'(tu); thr_V = 8'(tv);
    endtask

    task automatic f_clear();
        f_cnt = 0; f_rsum = 0; f_csum = 0;
        f_rmin = 8191; f_rmax = 0; f_cmin = 8191; f_cmax = 0;
    endtask

    // Advance one clock; mask outputs must show the inputs of two cycles earlier
    task automatic tick();
        @(negedge clk);
        chk("mask_valid", mask_valid, p_v);
        chk("mask", mask, p_m);
        if (p_v) begin
            chk("mask_row", mask_row, p_row);
            chk("mask_col", mask_col, p_col);
        end
        if (result_stb) stb_cnt++;
        p_v = c_v; p_m = c_m; p_row = c_row; p_col = c_col;
    endtask

    task automatic drive(input int r, input int g, input int b, input int rw, input int cl,
                         input bit v, input bit s, input bit e);
        raw_R = 8'(r); raw_G = 8'(g); raw_B = 8'(b);
        row = 13'(rw); col = 13'(cl); pix_valid = v; sof = s; eof = e;
        c_v = v; c_m = v && model_match(r, g, b); c_row = rw; c_col = cl;
        if (s) f_clear();
        if (c_m) begin
            f_cnt++; f_rsum += rw; f_csum += cl;
            if (rw < f_rmin) f_rmin = rw;
            if (rw > f_rmax) f_rmax = rw;
            if (cl < f_cmin) f_cmin = cl;
            if (cl > f_cmax) f_cmax = cl;
        end
        if (e && !eof_drop) begin
            e_cnt = f_cnt; e_rsum = f_rsum; e_csum = f_csum;
            e_rmin = f_rmin; e_rmax = f_rmax; e_cmin = f_cmin; e_cmax = f_cmax;
            f_clear();
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Wait (bounded) for the result strobe, then compare against the expected frame
    task automatic wait_result(input string tag);
        int n;
        longint er, ec;
        n = 0;
        stb_cnt = 0;
        while (stb_cnt == 0 && n < 300) begin
            idle(1);
            n++;
        end
        chk({tag, "_stb_seen"}, stb_cnt, 1);
        er = (e_cnt == 0) ? 0 : e_rsum / e_cnt;
        ec = (e_cnt == 0) ? 0 : e_csum / e_cnt;
        chk({tag, "_match_cnt"}, match_cnt, e_cnt);
        chk({tag, "_result_valid"}, result_valid, (e_cnt >= 16));
        chk({tag, "_cen_row"}, cen_row, er);
        chk({tag, "_cen_col"}, cen_col, ec);
        chk({tag, "_box_rmin"}, box_rmin, e_rmin);
        chk({tag, "_box_rmax"}, box_rmax, e_rmax);
        chk({tag, "_box_cmin"}, box_cmin, e_cmin);
        chk({tag, "_box_cmax"}, box_cmax, e_cmax);
        idle(5);
        chk({tag, "_stb_once"}, stb_cnt, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mask"}, mask, 0);
        chk({tag, "_mask_valid"}, mask_valid, 0);
        chk({tag, "_box"}, {box_rmin, box_rmax, box_cmin, box_cmax}, 0);
        chk({tag, "_cen"}, {cen_row, cen_col}, 0);
        chk({tag, "_match_cnt"}, match_cnt, 0);
        chk({tag, "_flags"}, {result_valid, result_stb, overrun}, 0);
    endtask

    task automatic rand_frame(input int npix);
        int base;
        set_ref($urandom_range(60, 200), int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4,
                $urandom_range(3, 12), $urandom_range(3, 12), $urandom_range(3, 12));
        base = m_refy * 256 / 264;
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < npix; k++) begin
            drive(clamp8(base + int'($urandom_range(0, 12)) - 6),
                  clamp8(base + int'($urandom_range(0, 12)) - 6),
                  clamp8(base + int'($urandom_range(0, 12)) - 6),
                  $urandom_range(0, 8191), $urandom_range(0, 8191),
                  ($urandom_range(0, 9) != 0), 1'b0, (k == npix - 1));
        end
    endtask

    initial begin
        reset_n = 1'b0; cal_done = 1'b0; eof_drop = 1'b0;
        raw_R = 0; raw_G = 0; raw_B = 0; row = 0; col = 0; pix_valid = 0; sof = 0; eof = 0;
        set_ref(100, 0, 0, 4, 4, 4);
        p_v = 0; p_m = 0; c_v = 0; c_m = 0; p_row = 0; p_col = 0; c_row = 0; c_col = 0;
        f_clear();
        e_cnt = 0; e_rsum = 0; e_csum = 0; e_rmin = 8191; e_rmax = 0; e_cmin = 8191; e_cmax = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        cal_done = 1'b1;

        // Single match / single mismatch with exact 2-cycle latency
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        drive(100, 100, 100, 10, 20, 1'b1, 1'b0, 1'b0);
        drive(200, 100, 100, 11, 21, 1'b1, 1'b0, 1'b0);
        chk("gray_mask", mask, 1);
        chk("gray_row", mask_row, 10);
        chk("gray_col", mask_col, 20);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("red_mask", mask, 0);
        chk("red_valid", mask_valid, 1);
        wait_result("single");

        // 4x4 block; cal_done dropped while dividing must not disturb the result
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int r = 50; r <= 53; r++)
            for (int c = 80; c <= 83; c++)
                drive(100, 100, 100, r, c, 1'b1, 1'b0, (r == 53 && c == 83));
        idle(3);
        cal_done = 1'b0;
        wait_result("block");
        chk("block_cnt16", match_cnt, 16);
        chk("block_cen", {cen_row, cen_col}, {13'd51, 13'd81});
        chk("block_box", {box_rmin, box_rmax, box_cmin, box_cmax}, {13'd50, 13'd53, 13'd80, 13'd83});
        chk("block_valid", result_valid, 1);
        cal_done = 1'b1;

        // Three matches: below MIN_PIX
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive(100, 100, 100, 7 + k, 900 - k, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        wait_result("three");
        chk("three_cnt", match_cnt, 3);
        chk("three_valid", result_valid, 0);

        // No matches: divide skipped, centroid 0
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive(200, 100, 100, k, k, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        wait_result("empty");
        chk("empty_cen", {cen_row, cen_col}, 0);

        // Overrun: second eof lands during the divide and is dropped
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) drive(100, 100, 100, 300 + k, 4000 + 2 * k, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(9);
        eof_drop = 1'b1;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        eof_drop = 1'b0;
        wait_result("ovr_first");
        chk("overrun_set", overrun, 1);
        rand_frame(40);
        wait_result("ovr_next");
        chk("overrun_sticky", overrun, 1);

        // Randomised frames
        for (int f = 0; f < 3; f++) begin
            rand_frame(60);
            wait_result("rand");
        end

        // Reset in the middle of a divide
        set_ref(100, 0, 0, 4, 4, 4);
        idle(2);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) drive(100, 100, 100, 1000 + k, 2000 + k, 1'b1, 1'b0, (k == 15));
        idle(20);
        #3 reset_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        p_v = 0; p_m = 0; c_v = 0; c_m = 0;
        f_clear();
        reset_n = 1'b1;
        stb_cnt = 0;
        idle(150);
        chk("no_stb_after_reset", stb_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
